y86_mem_arbiter: RTL and testbench
==================================

// Module: y86_mem_arbiter
// PURPOSE
//  Shares the single-port Y86 data memory between two requesters: instruction fetch (IF, read-only)
//  and the memory stage (DM, read/write for mrmovq/rmmovq/call/ret/pushq/popq).
//  Accepts one request at a time over valid/ready and drives the RAM.
//  Returns read data or a write acknowledge to the granted requester.
//  Sits between the fetch/memory stages and the memory array of the pipelined core.
// PARAMETERS
//  DATA_W   64  word width of requests, responses and RAM
//  ADDR_W   64  requester address width (word address)
//  MEM_AW    7  RAM address width; mem_addr = req_addr[MEM_AW-1:0] (128 words)
//  MEM_LAT   1  cycles from mem_en to valid mem_rdata; legal range 1..15
// PORTS
//  clk            in   1       rising-edge clock
//  rst_n          in   1       asynchronous active-low reset
//  if_req_valid   in   1       IF read request
//  if_req_ready   out  1       IF request accepted this cycle
//  if_addr        in   ADDR_W  IF address
//  if_rsp_valid   out  1       IF response pulse (1 cycle)
//  if_rsp_data    out  DATA_W  IF read data
//  dm_req_valid   in   1       DM request
//  dm_req_ready   out  1       DM request accepted this cycle
//  dm_we          in   1       1 = write, 0 = read
//  dm_addr        in   ADDR_W  DM address
//  dm_wdata       in   DATA_W  DM write data
//  dm_rsp_valid   out  1       DM response pulse (read data or write ack)
//  dm_rsp_data    out  DATA_W  DM read data; 0 for write ack
//  mem_en         out  1       RAM access strobe (1 cycle)
//  mem_we         out  1       RAM write enable, qualified by mem_en
//  mem_addr       out  MEM_AW  RAM address
//  mem_wdata      out  DATA_W  RAM write data
//  mem_rdata      in   DATA_W  RAM read data, valid MEM_LAT cycles after mem_en
//  busy           out  1       state != IDLE
// BEHAVIOUR
//  - FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  - IDLE: ready is raised combinationally for the arbitration winner only; the loser's ready = 0.
//    Handshake = valid & ready. On handshake, latch port id, we, addr, wdata; go to ISSUE.
//  - ISSUE (1 cycle): mem_en = 1 with mem_we/mem_addr/mem_wdata from the latch. Load cnt = MEM_LAT.
//  - WAIT: cnt decrements each cycle. When cnt reaches 0, capture mem_rdata (writes capture 0) and go to RESP.
//  - RESP (1 cycle): the granted port's rsp_valid = 1 with rsp_data. The other port's rsp_valid = 0. Then IDLE.
//  - Timing: handshake in cycle T gives mem_en at T+1, rdata at T+1+MEM_LAT, rsp_valid at T+2+MEM_LAT.
//    The next handshake is possible at T+3+MEM_LAT.
//  - Responses are not back-pressured; requesters must sink rsp_valid.
//  - Address wrap: bits above MEM_AW are ignored (addr 130 maps to word 2).
//  - Requests not granted keep valid asserted. Dropping valid before ready is legal and nothing is issued.
//  - Arbitration (default, fixed priority): DM wins when both are valid, because DM holds the older instruction.
//  - Reset (async, any state): state = IDLE. All outputs 0: ready, rsp_valid, rsp_data, mem_en, mem_we,
//    mem_addr, mem_wdata, busy. The in-flight transaction is dropped without a response.
//    A RAM write already strobed is not undone.
// CONFIGURATION
//  MEM_ARB_RR_EN defined: round-robin arbitration.
//   - A 1-bit last_gnt register resets to DM (so IF wins the first tie).
//   - On a tie, grant the port != last_gnt. last_gnt updates on every handshake.
//   - A single valid requester is always granted.
//  MEM_ARB_RR_EN undefined: fixed DM-over-IF priority; the last_gnt register is not present.
// STRUCTURE
//  - Package y86_mem_pkg holds:
//    - the state enum typedef (IDLE/ISSUE/WAIT/RESP)
//    - port-id constants PORT_IF = 0 and PORT_DM = 1
//    - DATA_W and MEM_AW defaults
//    - the counter width constant LAT_W = 4
//  - Sub-module y86_mem_rr_pick: 2-way grant select.
//    Inputs: valids and last_gnt. Output: a one-hot grant.
//    Fixed priority is selected by a tie-off when MEM_ARB_RR_EN is undefined.
// TESTING
//  - Reset mid-WAIT: assert rst_n = 0 during WAIT -> all outputs 0 the same cycle, no rsp_valid after release, busy = 0.
//  - DM write then read (MEM_LAT = 1):
//    - dm_we = 1, addr 5, wdata 0xDEAD -> mem_en/mem_we at T+1, dm_rsp_valid at T+3 with data 0.
//    - Read addr 5 -> dm_rsp_data = 0xDEAD.
//  - IF read, MEM_LAT = 3: preload word 9 = 0x1234, if_addr = 9 -> if_rsp_valid exactly at T+5, data 0x1234, dm_rsp_valid stays 0.
//  - Tie, fixed priority: both valid, IF addr 1 and DM read addr 2 -> DM granted first.
//    IF granted at T+4 (MEM_LAT = 1). Responses carry word 1 and word 2 respectively.
//  - Tie with MEM_ARB_RR_EN: both held valid for 4 transactions -> grant order IF, DM, IF, DM.
//  - Address wrap: DM write addr 130, wdata 0x77; IF read addr 2 -> if_rsp_data = 0x77.

Source files
------------

// File: rtl/y86_mem_pkg.sv
// Shared types and constants for the Y86 data-memory arbiter.
package y86_mem_pkg;

    localparam int unsigned DATA_W_DEF = 64;
    localparam int unsigned MEM_AW_DEF = 7;
    localparam int unsigned LAT_W      = 4;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DM = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } arb_state_e;

endpackage

// File: rtl/y86_mem_rr_pick.sv
// Two-way grant select between IF and DM; a tie goes to the port that was not granted last.
module y86_mem_rr_pick
    import y86_mem_pkg::*;
(
    input  logic [1:0] valid_i,
    input  logic       last_gnt_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        if (valid_i[PORT_IF] && valid_i[PORT_DM]) begin
            if (last_gnt_i == PORT_DM) begin
                gnt_o[PORT_IF] = 1'b1;
            end else begin
                gnt_o[PORT_DM] = 1'b1;
            end
        end else begin
            gnt_o = valid_i;
        end
    end

endmodule

// File: rtl/y86_mem_arbiter.sv
// Shares the single-port Y86 data memory between instruction fetch and the memory stage.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise DM has fixed priority over IF.
module y86_mem_arbiter
    import y86_mem_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned MEM_AW  = MEM_AW_DEF,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,

    input  logic              dm_req_valid,
    output logic              dm_req_ready,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_rsp_valid,
    output logic [DATA_W-1:0] dm_rsp_data,

    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    arb_state_e        state_q, state_d;
    logic [LAT_W-1:0]  cnt_q, cnt_d;
    logic              port_q, port_d;
    logic              we_q, we_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic [1:0]        gnt;
    logic              last_gnt;
    logic              hs;

    // Upper address bits are ignored: the RAM wraps at 2**MEM_AW words.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{if_addr[ADDR_W-1:MEM_AW], dm_addr[ADDR_W-1:MEM_AW]};

    y86_mem_rr_pick u_pick (
        .valid_i    ({dm_req_valid, if_req_valid}),
        .last_gnt_i (last_gnt),
        .gnt_o      (gnt)
    );

    assign hs = (state_q == StIdle) && (gnt != 2'b00);

`ifdef MEM_ARB_RR_EN
    logic last_gnt_q, last_gnt_d;

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (hs) begin
            last_gnt_d = gnt[PORT_DM] ? PORT_DM : PORT_IF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q <= PORT_DM;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

    assign last_gnt = last_gnt_q;
`else
    // Pretending IF was granted last makes every tie go to DM.
    assign last_gnt = PORT_IF;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        port_d  = port_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                if (hs) begin
                    port_d  = gnt[PORT_DM] ? PORT_DM : PORT_IF;
                    we_d    = gnt[PORT_DM] & dm_we;
                    addr_d  = gnt[PORT_DM] ? dm_addr[MEM_AW-1:0] : if_addr[MEM_AW-1:0];
                    wdata_d = gnt[PORT_DM] ? dm_wdata : '0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = LAT_W'(MEM_LAT);
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == LAT_W'(1)) begin
                    data_d  = we_q ? '0 : mem_rdata;
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            port_q  <= PORT_IF;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            port_q  <= port_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
        end
    end

    // Ready is gated by rst_n so every output reads 0 while reset is held.
    always_comb begin
        if_req_ready = rst_n && (state_q == StIdle) && gnt[PORT_IF];
        dm_req_ready = rst_n && (state_q == StIdle) && gnt[PORT_DM];
        if_rsp_valid = (state_q == StResp) && (port_q == PORT_IF);
        dm_rsp_valid = (state_q == StResp) && (port_q == PORT_DM);
        if_rsp_data  = if_rsp_valid ? data_q : '0;
        dm_rsp_data  = dm_rsp_valid ? data_q : '0;
        mem_en       = (state_q == StIssue);
        mem_we       = mem_en & we_q;
        mem_addr     = mem_en ? addr_q : '0;
        mem_wdata    = mem_en ? wdata_q : '0;
        busy         = (state_q != StIdle);
    end

endmodule

// File: tb/tb_y86_mem_arbiter.sv
// Directed bench for y86_mem_arbiter: one instance with MEM_LAT=1, one with MEM_LAT=3.
module tb_y86_mem_arbiter;

    logic        clk;
    logic        rst_n;

    logic        if_req_valid [2];
    logic        if_req_ready [2];
    logic [63:0] if_addr      [2];
    logic        if_rsp_valid [2];
    logic [63:0] if_rsp_data  [2];
    logic        dm_req_valid [2];
    logic        dm_req_ready [2];
    logic        dm_we        [2];
    logic [63:0] dm_addr      [2];
    logic [63:0] dm_wdata     [2];
    logic        dm_rsp_valid [2];
    logic [63:0] dm_rsp_data  [2];
    logic        mem_en       [2];
    logic        mem_we       [2];
    logic [6:0]  mem_addr     [2];
    logic [63:0] mem_wdata    [2];
    logic [63:0] mem_rdata    [2];
    logic        busy         [2];

    int n_tests = 0;
    int n_fail  = 0;

    y86_mem_arbiter #(.MEM_LAT(1)) u_dut_l1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_req_valid (if_req_valid[0]),
        .if_req_ready (if_req_ready[0]),
        .if_addr      (if_addr[0]),
        .if_rsp_valid (if_rsp_valid[0]),
        .if_rsp_data  (if_rsp_data[0]),
        .dm_req_valid (dm_req_valid[0]),
        .dm_req_ready (dm_req_ready[0]),
        .dm_we        (dm_we[0]),
        .dm_addr      (dm_addr[0]),
        .dm_wdata     (dm_wdata[0]),
        .dm_rsp_valid (dm_rsp_valid[0]),
        .dm_rsp_data  (dm_rsp_data[0]),
        .mem_en       (mem_en[0]),
        .mem_we       (mem_we[0]),
        .mem_addr     (mem_addr[0]),
        .mem_wdata    (mem_wdata[0]),
        .mem_rdata    (mem_rdata[0]),
        .busy         (busy[0])
    );

    y86_mem_arbiter #(.MEM_LAT(3)) u_dut_l3 (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_req_valid (if_req_valid[1]),
        .if_req_ready (if_req_ready[1]),
        .if_addr      (if_addr[1]),
        .if_rsp_valid (if_rsp_valid[1]),
        .if_rsp_data  (if_rsp_data[1]),
        .dm_req_valid (dm_req_valid[1]),
        .dm_req_ready (dm_req_ready[1]),
        .dm_we        (dm_we[1]),
        .dm_addr      (dm_addr[1]),
        .dm_wdata     (dm_wdata[1]),
        .dm_rsp_valid (dm_rsp_valid[1]),
        .dm_rsp_data  (dm_rsp_data[1]),
        .mem_en       (mem_en[1]),
        .mem_we       (mem_we[1]),
        .mem_addr     (mem_addr[1]),
        .mem_wdata    (mem_wdata[1]),
        .mem_rdata    (mem_rdata[1]),
        .busy         (busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models: read data appears MEM_LAT cycles after mem_en, zero otherwise.
    logic [63:0] ram0 [128];
    logic [63:0] ram1 [128];
    logic [63:0] pipe0;
    logic [63:0] pipe1 [3];

    always @(posedge clk) begin
        pipe0 <= 64'd0;
        if (mem_en[0]) begin
            if (mem_we[0]) ram0[mem_addr[0]] <= mem_wdata[0];
            else           pipe0 <= ram0[mem_addr[0]];
        end
    end
    assign mem_rdata[0] = pipe0;

    always @(posedge clk) begin
        pipe1[0] <= 64'd0;
        pipe1[1] <= pipe1[0];
        pipe1[2] <= pipe1[1];
        if (mem_en[1]) begin
            if (mem_we[1]) ram1[mem_addr[1]] <= mem_wdata[1];
            else           pipe1[0] <= ram1[mem_addr[1]];
        end
    end
    assign mem_rdata[1] = pipe1[2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_idle_outs(input int d, input string tag);
        check({tag, " if_req_ready"}, 64'(if_req_ready[d]), 64'd0);
        check({tag, " dm_req_ready"}, 64'(dm_req_ready[d]), 64'd0);
        check({tag, " if_rsp_valid"}, 64'(if_rsp_valid[d]), 64'd0);
        check({tag, " dm_rsp_valid"}, 64'(dm_rsp_valid[d]), 64'd0);
        check({tag, " if_rsp_data"},  if_rsp_data[d],       64'd0);
        check({tag, " dm_rsp_data"},  dm_rsp_data[d],       64'd0);
        check({tag, " mem_en"},       64'(mem_en[d]),       64'd0);
        check({tag, " mem_we"},       64'(mem_we[d]),       64'd0);
        check({tag, " mem_addr"},     64'(mem_addr[d]),     64'd0);
        check({tag, " mem_wdata"},    mem_wdata[d],         64'd0);
        check({tag, " busy"},         64'(busy[d]),         64'd0);
    endtask

    // Single transaction on instance d; port 1 = DM, 0 = IF.
    task automatic txn(input int d, input bit port, input bit we, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [63:0] exp, input string name);
        int lat;
        int n;
        int bad;
        bit got;
        lat = (d == 0) ? 1 : 3;
        @(negedge clk);
        if (port) begin
            dm_req_valid[d] = 1'b1;
            dm_we[d]        = we;
            dm_addr[d]      = addr;
            dm_wdata[d]     = wdata;
        end else begin
            if_req_valid[d] = 1'b1;
            if_addr[d]      = addr;
        end
        #1;
        check({name, " ready"}, 64'(port ? dm_req_ready[d] : if_req_ready[d]), 64'd1);
        @(posedge clk);
        #1;
        if_req_valid[d] = 1'b0;
        dm_req_valid[d] = 1'b0;
        check({name, " mem_en"},   64'(mem_en[d]),   64'd1);
        check({name, " mem_we"},   64'(mem_we[d]),   64'(we));
        check({name, " mem_addr"}, 64'(mem_addr[d]), addr & 64'd127);
        if (we) check({name, " mem_wdata"}, mem_wdata[d], wdata);
        n   = 0;
        bad = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            if (port ? if_rsp_valid[d] : dm_rsp_valid[d]) bad++;
            if (port ? dm_rsp_valid[d] : if_rsp_valid[d]) begin
                got = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        check({name, " rsp latency"}, 64'(n), 64'(lat + 1));
        check({name, " rsp_data"}, port ? dm_rsp_data[d] : if_rsp_data[d], exp);
        check({name, " other rsp_valid"}, 64'(bad), 64'd0);
        @(posedge clk);
        #1;
        check({name, " busy after"}, 64'(busy[d]), 64'd0);
    endtask

    typedef struct {
        bit          port;
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dm_cyc, if_gnt_cyc, if_cyc, cyc, bad;
        logic [63:0] dm_dat, if_dat;
        int gseq [4];
        int gcount, if_rsps, dm_rsps;
        bit pend_drop;

        vecs[0]  = '{1'b1, 1'b1, 64'd5,   64'hDEAD,               64'd0};
        vecs[1]  = '{1'b1, 1'b0, 64'd5,   64'd0,                  64'hDEAD};
        vecs[2]  = '{1'b1, 1'b1, 64'd130, 64'h77,                 64'd0};
        vecs[3]  = '{1'b0, 1'b0, 64'd2,   64'd0,                  64'h77};
        vecs[4]  = '{1'b1, 1'b1, 64'd1,   64'h1111,               64'd0};
        vecs[5]  = '{1'b1, 1'b1, 64'd2,   64'h2222,               64'd0};
        vecs[6]  = '{1'b0, 1'b0, 64'd1,   64'd0,                  64'h1111};
        vecs[7]  = '{1'b1, 1'b0, 64'd2,   64'd0,                  64'h2222};
        vecs[8]  = '{1'b1, 1'b1, 64'd127, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
        vecs[9]  = '{1'b0, 1'b0, 64'd255, 64'd0,                  64'hFFFF_FFFF_FFFF_FFFF};
        vecs[10] = '{1'b1, 1'b1, 64'd0,   64'hA5,                 64'd0};
        vecs[11] = '{1'b1, 1'b0, 64'hFFFF_0000_0000_0080, 64'd0,  64'hA5};

        for (int d = 0; d < 2; d++) begin
            if_req_valid[d] = 1'b1;
            if_addr[d]      = 64'd3;
            dm_req_valid[d] = 1'b1;
            dm_we[d]        = 1'b1;
            dm_addr[d]      = 64'd4;
            dm_wdata[d]     = 64'h55;
        end
        rst_n = 1'b0;
        #12;
        check_idle_outs(0, "reset l1");
        check_idle_outs(1, "reset l3");
        for (int d = 0; d < 2; d++) begin
            if_req_valid[d] = 1'b0;
            dm_req_valid[d] = 1'b0;
            dm_we[d]        = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            txn(0, vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp,
                $sformatf("vec%0d", i));
        end

        txn(1, 1'b1, 1'b1, 64'd9, 64'h1234, 64'd0, "l3 preload");
        txn(1, 1'b0, 1'b0, 64'd9, 64'd0, 64'h1234, "l3 if read");

        // Reset while the MEM_LAT=3 instance sits in WAIT.
        @(negedge clk);
        dm_req_valid[1] = 1'b1;
        dm_we[1]        = 1'b0;
        dm_addr[1]      = 64'd9;
        @(posedge clk);
        #1;
        dm_req_valid[1] = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("midwait busy before reset", 64'(busy[1]), 64'd1);
        dm_req_valid[1] = 1'b1;
        if_req_valid[1] = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outs(1, "midwait reset");
        dm_req_valid[1] = 1'b0;
        if_req_valid[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (dm_rsp_valid[1] || if_rsp_valid[1] || busy[1] || mem_en[1]) bad++;
        end
        check("midwait activity after release", 64'(bad), 64'd0);

`ifdef MEM_ARB_RR_EN
        gseq      = '{-1, -1, -1, -1};
        gcount    = 0;
        if_rsps   = 0;
        dm_rsps   = 0;
        bad       = 0;
        pend_drop = 1'b0;
        @(negedge clk);
        if_req_valid[0] = 1'b1;
        if_addr[0]      = 64'd1;
        dm_req_valid[0] = 1'b1;
        dm_we[0]        = 1'b0;
        dm_addr[0]      = 64'd2;
        #1;
        if (if_req_ready[0])      gseq[gcount++] = 0;
        else if (dm_req_ready[0]) gseq[gcount++] = 1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (pend_drop) begin
                if_req_valid[0] = 1'b0;
                dm_req_valid[0] = 1'b0;
                pend_drop = 1'b0;
            end
            if (if_rsp_valid[0]) begin
                if_rsps++;
                if (if_rsp_data[0] !== 64'h1111) bad++;
            end
            if (dm_rsp_valid[0]) begin
                dm_rsps++;
                if (dm_rsp_data[0] !== 64'h2222) bad++;
            end
            if (gcount < 4) begin
                if (if_req_ready[0])      gseq[gcount++] = 0;
                else if (dm_req_ready[0]) gseq[gcount++] = 1;
                if (gcount == 4) pend_drop = 1'b1;
            end
        end
        check("rr grant 0 (IF)", 64'(gseq[0]), 64'd0);
        check("rr grant 1 (DM)", 64'(gseq[1]), 64'd1);
        check("rr grant 2 (IF)", 64'(gseq[2]), 64'd0);
        check("rr grant 3 (DM)", 64'(gseq[3]), 64'd1);
        check("rr if responses", 64'(if_rsps), 64'd2);
        check("rr dm responses", 64'(dm_rsps), 64'd2);
        check("rr bad rsp data", 64'(bad), 64'd0);
`else
        dm_cyc     = -1;
        if_gnt_cyc = -1;
        if_cyc     = -1;
        dm_dat     = 64'd0;
        if_dat     = 64'd0;
        @(negedge clk);
        if_req_valid[0] = 1'b1;
        if_addr[0]      = 64'd1;
        dm_req_valid[0] = 1'b1;
        dm_we[0]        = 1'b0;
        dm_addr[0]      = 64'd2;
        #1;
        check("tie dm_req_ready", 64'(dm_req_ready[0]), 64'd1);
        check("tie if_req_ready", 64'(if_req_ready[0]), 64'd0);
        @(posedge clk);
        #1;
        dm_req_valid[0] = 1'b0;
        cyc = 1;
        while (cyc <= 12) begin
            if (if_gnt_cyc >= 0 && cyc == if_gnt_cyc + 1) if_req_valid[0] = 1'b0;
            if (dm_rsp_valid[0] && dm_cyc < 0) begin
                dm_cyc = cyc;
                dm_dat = dm_rsp_data[0];
            end
            if (if_rsp_valid[0] && if_cyc < 0) begin
                if_cyc = cyc;
                if_dat = if_rsp_data[0];
            end
            if (if_req_ready[0] && if_gnt_cyc < 0) if_gnt_cyc = cyc;
            @(posedge clk);
            #1;
            cyc++;
        end
        check("tie dm rsp cycle", 64'(dm_cyc), 64'd3);
        check("tie dm rsp data", dm_dat, 64'h2222);
        check("tie if grant cycle", 64'(if_gnt_cyc), 64'd4);
        check("tie if rsp cycle", 64'(if_cyc), 64'd7);
        check("tie if rsp data", if_dat, 64'h1111);
`endif

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
